codec_spi_init_seq: RTL and testbench

- Sequences a shared SPI master pin set to configure the audio codec after power-up.
- Walks an external table of NUM_REGS 16-bit command words and shifts each out as one SPI mode-0 frame.
- Arbitrates single-word host writes (from the NIOS PIO) against the boot sequence.
- Sits between the soc PIO/keycode side and the codec SPI pins; provides busy/done status to the top level.

---
 rtl/codec_spi_init_seq.sv | 197 +++++++++++++++++++
 tb/tb_codec_spi_init_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_spi_init_seq.sv
// Boot-time SPI configuration sequencer for the audio codec: walks a command table
// and shifts each word out as a mode-0 frame, interleaving single host writes.
module codec_spi_init_seq #(
    parameter int NUM_REGS   = 8,
    parameter int WORD_W     = 16,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              start,
    output logic [7:0]        rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    input  logic              wr_req,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_ss_n,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              done
);

    localparam int HC_W = $clog2(CLK_DIV) + 1;
    localparam int BC_W = $clog2(WORD_W) + 1;
    localparam int GC_W = $clog2(GAP_CYCLES) + 1;

    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(WORD_W - 1);
    localparam logic [GC_W-1:0] GC_LAST  = GC_W'(GAP_CYCLES - 1);
    localparam logic [7:0]      IDX_LAST = 8'(NUM_REGS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_SS_SETUP = 3'd2;
    localparam logic [2:0] S_SHIFT    = 3'd3;
    localparam logic [2:0] S_SS_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam logic SRC_ROM  = 1'b0;
    localparam logic SRC_HOST = 1'b1;

    logic [2:0]        state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic              done_q, done_d;
    logic              src_q, src_d;
    logic [WORD_W-1:0] tx_q, tx_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic [WORD_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              wr_ack_q, wr_ack_d;
    logic              ss_n_q, ss_n_d;
    logic              sclk_q, sclk_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [GC_W-1:0]   gcnt_q, gcnt_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        done_d     = done_q;
        src_d      = src_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        wr_ack_d   = 1'b0;
        sclk_d     = sclk_q;
        hcnt_d     = hcnt_q;
        bcnt_d     = bcnt_q;
        gcnt_d     = gcnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // start outranks a pending host write; the write is served later
                if (start) begin
                    idx_d   = 8'd0;
                    done_d  = 1'b0;
                    src_d   = SRC_ROM;
                    state_d = S_LOAD;
                end else if (wr_req) begin
                    tx_d     = wr_data;
                    wr_ack_d = 1'b1;
                    src_d    = SRC_HOST;
                    hcnt_d   = '0;
                    state_d  = S_SS_SETUP;
                end
            end
            S_LOAD: begin
                tx_d    = rom_data;
                hcnt_d  = '0;
                state_d = S_SS_SETUP;
            end
            S_SS_SETUP: begin
                if (hcnt_q == HC_LAST) begin
                    hcnt_d  = '0;
                    bcnt_d  = '0;
                    state_d = S_SHIFT;
                end else begin
                    hcnt_d = hcnt_q + HC_W'(1);
                end
            end
            S_SHIFT: begin
                if (hcnt_q != HC_LAST) begin
                    hcnt_d = hcnt_q + HC_W'(1);
                end else begin
                    hcnt_d = '0;
                    // sclk_q doubles as the phase bit of the current bit cell
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = (rx_q << 1) | WORD_W'(spi_miso);
                    end else begin
                        sclk_d = 1'b0;
                        tx_d   = tx_q << 1;
                        if (bcnt_q == BC_LAST) state_d = S_SS_HOLD;
                        else                   bcnt_d  = bcnt_q + BC_W'(1);
                    end
                end
            end
            S_SS_HOLD: begin
                if (hcnt_q == HC_LAST) begin
                    rx_data_d  = rx_q;
                    rx_valid_d = 1'b1;
                    gcnt_d     = '0;
                    state_d    = S_GAP;
                end else begin
                    hcnt_d = hcnt_q + HC_W'(1);
                end
            end
            S_GAP: begin
                if (gcnt_q == GC_LAST) begin
                    if (src_q == SRC_HOST) begin
                        state_d = done_q ? S_DONE : S_IDLE;
                    end else if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    gcnt_d = gcnt_q + GC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        ss_n_d = !(state_d inside {S_SS_SETUP, S_SHIFT, S_SS_HOLD});
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 8'd0;
            done_q     <= 1'b0;
            src_q      <= SRC_ROM;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            ss_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            hcnt_q     <= '0;
            bcnt_q     <= '0;
            gcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            src_q      <= src_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            wr_ack_q   <= wr_ack_d;
            ss_n_q     <= ss_n_d;
            sclk_q     <= sclk_d;
            hcnt_q     <= hcnt_d;
            bcnt_q     <= bcnt_d;
            gcnt_q     <= gcnt_d;
        end
    end

    assign rom_addr = idx_q;
    assign wr_ack   = wr_ack_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = tx_q[WORD_W-1];
    assign spi_ss_n = ss_n_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = done_q;

endmodule

// File: tb/tb_codec_spi_init_seq.sv
// Scoreboard bench for codec_spi_init_seq: stimulus pushes expected frames, SPI-side
// monitors decode MOSI frames and pop/compare them.
module tb_codec_spi_init_seq;

    typedef struct {
        logic [15:0] word;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset_reset;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // DUT A: default parameters, MISO looped back from MOSI
    logic        start_a, wr_req_a, wr_ack_a, sclk_a, mosi_a, ss_n_a, rx_valid_a, busy_a, done_a;
    logic [7:0]  rom_addr_a;
    logic [15:0] rom_data_a, wr_data_a, rx_data_a;
    logic [15:0] rom_a [8];
    initial rom_a = '{16'h1234, 16'h1235, 16'h1237, 16'h1238,
                      16'h123A, 16'h123C, 16'h123E, 16'h1240};
    assign rom_data_a = (rom_addr_a < 8'd8) ? rom_a[rom_addr_a[2:0]] : 16'hDEAD;

    codec_spi_init_seq dut_a (
        .clk_clk(clk), .reset_reset(reset_reset), .start(start_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .wr_req(wr_req_a), .wr_data(wr_data_a), .wr_ack(wr_ack_a),
        .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_miso(mosi_a), .spi_ss_n(ss_n_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a), .done(done_a)
    );

    // DUT B: one 8-bit entry, fast SCLK
    logic       start_b, wr_ack_b, sclk_b, mosi_b, ss_n_b, rx_valid_b, busy_b, done_b;
    logic [7:0] rom_addr_b, rom_data_b, rx_data_b;
    assign rom_data_b = (rom_addr_b == 8'd0) ? 8'hC5 : 8'h00;

    codec_spi_init_seq #(.NUM_REGS(1), .WORD_W(8), .CLK_DIV(2), .GAP_CYCLES(8)) dut_b (
        .clk_clk(clk), .reset_reset(reset_reset), .start(start_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .wr_req(1'b0), .wr_data(8'h00), .wr_ack(wr_ack_b),
        .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_miso(mosi_b), .spi_ss_n(ss_n_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b), .done(done_b)
    );

    // Monitor A
    exp_t        qa[$];
    exp_t        ea;
    logic        prev_ss_a = 1'b1, prev_sclk_a = 1'b0, in_a = 1'b0;
    logic [15:0] word_a;
    int          low_a, hi_a, bits_a, falls_a = 0, frames_a = 0, rxv_a = 0;

    always @(negedge clk) begin
        if (reset_reset) begin
            in_a = 1'b0; prev_ss_a = 1'b1; prev_sclk_a = 1'b0;
        end else begin
            if (rx_valid_a) rxv_a++;
            if (!ss_n_a) begin
                if (prev_ss_a) begin
                    falls_a++;
                    if (qa.size() == 0) chk("a_frame_expected", 32'd0, 32'd1);
                    else if (qa[0].gap > 0) chk("a_gap_high_cycles", hi_a, qa[0].gap);
                    in_a = 1'b1; low_a = 1; word_a = '0; bits_a = 0;
                end else begin
                    low_a++;
                end
                if (sclk_a && !prev_sclk_a) begin
                    word_a = {word_a[14:0], mosi_a};
                    bits_a++;
                end
            end else begin
                if (!prev_ss_a) begin
                    hi_a = 1;
                    if (in_a && qa.size() > 0) begin
                        ea = qa.pop_front();
                        chk("a_mosi_word", word_a, ea.word);
                        chk("a_bits", bits_a, 16);
                        chk("a_ss_low_cycles", low_a, 136);
                        chk("a_rx_valid_at_ss_rise", rx_valid_a, 1'b1);
                        chk("a_rx_data", rx_data_a, ea.word);
                        frames_a++;
                    end
                    in_a = 1'b0;
                end else begin
                    hi_a++;
                end
            end
            prev_ss_a = ss_n_a; prev_sclk_a = sclk_a;
        end
    end

    // Monitor B
    logic [7:0] qb[$];
    logic [7:0] eb, word_b;
    logic       prev_ss_b = 1'b1, prev_sclk_b = 1'b0, in_b = 1'b0;
    int         low_b, bits_b, last_rise_b, frames_b = 0;

    always @(negedge clk) begin
        if (reset_reset) begin
            in_b = 1'b0; prev_ss_b = 1'b1; prev_sclk_b = 1'b0;
        end else begin
            if (!ss_n_b) begin
                if (prev_ss_b) begin
                    if (qb.size() == 0) chk("b_frame_expected", 32'd0, 32'd1);
                    in_b = 1'b1; low_b = 1; word_b = '0; bits_b = 0; last_rise_b = -1;
                end else begin
                    low_b++;
                end
                if (sclk_b && !prev_sclk_b) begin
                    if (last_rise_b >= 0) chk("b_sclk_period", cyc - last_rise_b, 4);
                    last_rise_b = cyc;
                    word_b = {word_b[6:0], mosi_b};
                    bits_b++;
                end
            end else if (!prev_ss_b) begin
                if (in_b && qb.size() > 0) begin
                    eb = qb.pop_front();
                    chk("b_mosi_word", word_b, eb);
                    chk("b_bits", bits_b, 8);
                    chk("b_ss_low_cycles", low_b, 36);
                    chk("b_rx_valid_at_ss_rise", rx_valid_b, 1'b1);
                    chk("b_rx_data", rx_data_b, eb);
                    chk("b_rom_addr", rom_addr_b, 8'd0);
                    frames_b++;
                end
                in_b = 1'b0;
            end
            prev_ss_b = ss_n_b; prev_sclk_b = sclk_b;
        end
    end

    task automatic push_table();
        for (int i = 0; i < 8; i++) qa.push_back(exp_t'{rom_a[i], (i == 0) ? -1 : 9});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_reset = 1'b1;
        start_a = 1'b0; wr_req_a = 1'b0; wr_data_a = '0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        reset_reset = 1'b0;
        @(negedge clk);
        chk("rst_ss_n", ss_n_a, 1'b1);
        chk("rst_sclk", sclk_a, 1'b0);
        chk("rst_mosi", mosi_a, 1'b0);
        chk("rst_busy_done", {busy_a, done_a, wr_ack_a, rx_valid_a}, 4'b0000);
        chk("rst_rx_data", rx_data_a, 16'h0000);

        // Sequence aborted by reset in the middle of frame 3
        push_table();
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        for (int i = 0; i < 3000 && falls_a < 3; i++) @(negedge clk);
        chk("t1_reach_frame3", falls_a >= 3, 1'b1);
        repeat (40) @(negedge clk);
        chk("t1_in_frame", {ss_n_a, busy_a}, 2'b01);
        @(posedge clk); #2;
        reset_reset = 1'b1;
        #1;
        chk("t1_async_ss_n", ss_n_a, 1'b1);
        chk("t1_async_sclk", sclk_a, 1'b0);
        chk("t1_async_busy_done", {busy_a, done_a}, 2'b00);
        chk("t1_async_rom_addr", rom_addr_a, 8'd0);
        chk("t1_async_rx_data", rx_data_a, 16'h0000);
        qa.delete();
        @(negedge clk); @(negedge clk);
        reset_reset = 1'b0;
        chk("t1_frames_before_abort", frames_a, 2);

        // Host write from IDLE; start during the frame is ignored
        qa.push_back(exp_t'{16'hA5C3, -1});
        wr_data_a = 16'hA5C3; wr_req_a = 1'b1;
        for (int i = 0; i < 20 && !wr_ack_a; i++) @(negedge clk);
        chk("t2_wr_ack_seen", wr_ack_a, 1'b1);
        wr_req_a = 1'b0;
        @(negedge clk);
        chk("t2_wr_ack_one_cycle", wr_ack_a, 1'b0);
        repeat (20) @(negedge clk);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        for (int i = 0; i < 400 && busy_a; i++) @(negedge clk);
        chk("t2_idle_after_host", busy_a, 1'b0);
        chk("t2_done_stays_0", done_a, 1'b0);
        repeat (30) @(negedge clk);
        chk("t2_no_extra_frame", falls_a, 4);
        chk("t2_frames", frames_a, 3);
        chk("t2_ss_idle", ss_n_a, 1'b1);

        // Full table sequence after reset starts at entry 0
        push_table();
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        chk("t3_load_rom_addr", rom_addr_a, 8'd0);
        chk("t3_busy", busy_a, 1'b1);
        for (int i = 0; i < 3000 && !done_a; i++) @(negedge clk);
        chk("t3_done", done_a, 1'b1);
        chk("t3_busy_low", busy_a, 1'b0);
        chk("t3_queue_drained", qa.size(), 0);
        chk("t3_frames", frames_a, 11);

        // start and wr_req together in DONE: table first, then host word
        push_table();
        qa.push_back(exp_t'{16'h5A3C, 9});
        start_a = 1'b1; wr_req_a = 1'b1; wr_data_a = 16'h5A3C;
        @(negedge clk); start_a = 1'b0;
        chk("t4_done_cleared", done_a, 1'b0);
        chk("t4_no_early_ack", wr_ack_a, 1'b0);
        chk("t4_busy", busy_a, 1'b1);
        for (int i = 0; i < 3000 && !wr_ack_a; i++) @(negedge clk);
        chk("t4_wr_ack_seen", wr_ack_a, 1'b1);
        chk("t4_done_at_ack", done_a, 1'b1);
        chk("t4_frames_at_ack", frames_a, 19);
        wr_req_a = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 400 && busy_a; i++) @(negedge clk);
        chk("t4_busy_low", busy_a, 1'b0);
        chk("t4_done_final", done_a, 1'b1);
        chk("t4_frames", frames_a, 20);
        chk("t4_queue_drained", qa.size(), 0);
        chk("a_rx_valid_once_per_frame", rxv_a, frames_a);

        // Small configuration: one 8-bit entry
        qb.push_back(8'hC5);
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        for (int i = 0; i < 500 && !done_b; i++) @(negedge clk);
        chk("t5_done", done_b, 1'b1);
        chk("t5_busy_low", busy_b, 1'b0);
        repeat (30) @(negedge clk);
        chk("t5_one_frame", frames_b, 1);
        chk("t5_ss_idle", ss_n_b, 1'b1);
        chk("t5_rom_addr", rom_addr_b, 8'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
